axi_lite_reg_slave: RTL

AXI4-Lite responder holding the bypass controller's control/status register bank on the S00_AXI port. It accepts write and read transactions from the AXI master (the VIP master in simulation, the host-side interconnect in hardware) and answers with OKAY or SLVERR responses. It drives the register contents to the bypass datapath as flat outputs, with a one-cycle write strobe per register.

---
 rtl/axi_lite_reg_slave_if.sv | 41 ++++
 rtl/axi_lite_reg_slave.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_reg_slave_if.sv
// AXI4-Lite bus bundle for the bypass controller register port (S00_AXI).
// Groups the five AXI4-Lite channels; clock and reset stay outside.
//   master modport : drives AW/W/AR address, data and VALIDs, BREADY, RREADY
//   slave modport  : drives AWREADY/WREADY/ARREADY, B response, R data/response
// Parameters: AW = byte address width, DW = data width (32 only).
interface axi_lite_reg_slave_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic [AW-1:0]   awaddr;
  logic [2:0]      awprot;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wvalid;
  logic            wready;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [AW-1:0]   araddr;
  logic [2:0]      arprot;
  logic            arvalid;
  logic            arready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite responder for the bypass controller control/status register bank.
// Ports:
//   ACLK          sole clock, rising edge
//   ARESET        synchronous active-high reset
//   s_axi         AXI4-Lite slave port (AW, W, B, AR, R channels)
//   reg_out       register contents, register k at [32k+31:32k]
//   reg_wr_pulse  bit k high for one cycle after register k is written
//
// Write FSM
//   state     | meaning
//   W_IDLE    | waiting for AW and W; both READYs high
//   W_HAVE_AW | address latched, waiting for W
//   W_HAVE_W  | data/strobe latched, waiting for AW
//   W_RESP    | write committed, BVALID high until BREADY
// Read FSM
//   state     | meaning
//   R_IDLE    | ARREADY high, waiting for AR
//   R_DATA    | RDATA/RRESP loaded, RVALID high until RREADY
module axi_lite_reg_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int NUM_REGS           = 4
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  axi_lite_reg_slave_if.slave      s_axi,
  output logic [32*NUM_REGS-1:0]   reg_out,
  output logic [NUM_REGS-1:0]      reg_wr_pulse
);
  // Only a 32-bit data bus is supported.
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int IW = AW - 2;
  // One extra bit so NUM_REGS == 2^IW does not wrap to zero in the range compare.
  localparam logic [IW:0] NUM_REGS_W = (IW+1)'(NUM_REGS);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  wr_state_t       wr_state;
  rd_state_t       rd_state;
  logic [31:0]     regs [NUM_REGS];

  logic [IW-1:0]   aw_idx_q;
  logic [DW-1:0]   wdata_q;
  logic [DW/8-1:0] wstrb_q;

  logic            aw_hs, w_hs, ar_hs;
  logic            commit;
  logic            commit_in_range;
  logic [IW-1:0]   commit_idx;
  logic [DW-1:0]   commit_data;
  logic [DW/8-1:0] commit_strb;
  logic [IW-1:0]   ar_idx;
  logic            ar_in_range;
  logic [31:0]     rd_word;

  // READYs decode straight from state so they are 1 in the very first cycle
  // after reset releases, and forced low while reset is held.
  assign s_axi.awready = !ARESET && (wr_state == W_IDLE || wr_state == W_HAVE_W);
  assign s_axi.wready  = !ARESET && (wr_state == W_IDLE || wr_state == W_HAVE_AW);
  assign s_axi.arready = !ARESET && (rd_state == R_IDLE);

  assign aw_hs = s_axi.awvalid && s_axi.awready;
  assign w_hs  = s_axi.wvalid  && s_axi.wready;
  assign ar_hs = s_axi.arvalid && s_axi.arready;

  // The second handshake commits; whichever half arrived earlier comes from
  // the latches, the half arriving now comes straight off the bus.
  always_comb begin
    commit      = 1'b0;
    commit_idx  = aw_idx_q;
    commit_data = wdata_q;
    commit_strb = wstrb_q;
    case (wr_state)
      W_IDLE: begin
        commit      = aw_hs && w_hs;
        commit_idx  = s_axi.awaddr[AW-1:2];
        commit_data = s_axi.wdata;
        commit_strb = s_axi.wstrb;
      end
      W_HAVE_AW: begin
        commit      = w_hs;
        commit_data = s_axi.wdata;
        commit_strb = s_axi.wstrb;
      end
      W_HAVE_W: begin
        commit     = aw_hs;
        commit_idx = s_axi.awaddr[AW-1:2];
      end
      default: ;
    endcase
  end

  assign commit_in_range = {1'b0, commit_idx} < NUM_REGS_W;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_state     <= W_IDLE;
      s_axi.bvalid <= 1'b0;
      s_axi.bresp  <= RESP_OKAY;
      reg_wr_pulse <= '0;
      aw_idx_q     <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
    end else begin
      reg_wr_pulse <= '0;
      if (commit) begin
        for (int k = 0; k < NUM_REGS; k++) begin
          if (commit_in_range && commit_idx == IW'(k)) begin
            // Pulse even with an all-zero strobe: the datapath sees the access.
            reg_wr_pulse[k] <= 1'b1;
            for (int b = 0; b < DW/8; b++) begin
              if (commit_strb[b]) regs[k][8*b +: 8] <= commit_data[8*b +: 8];
            end
          end
        end
        s_axi.bresp  <= commit_in_range ? RESP_OKAY : RESP_SLVERR;
        s_axi.bvalid <= 1'b1;
      end
      case (wr_state)
        W_IDLE: begin
          if (aw_hs && w_hs) begin
            wr_state <= W_RESP;
          end else if (aw_hs) begin
            aw_idx_q <= s_axi.awaddr[AW-1:2];
            wr_state <= W_HAVE_AW;
          end else if (w_hs) begin
            wdata_q  <= s_axi.wdata;
            wstrb_q  <= s_axi.wstrb;
            wr_state <= W_HAVE_W;
          end
        end
        W_HAVE_AW: if (w_hs)  wr_state <= W_RESP;
        W_HAVE_W:  if (aw_hs) wr_state <= W_RESP;
        W_RESP: begin
          if (s_axi.bready) begin
            s_axi.bvalid <= 1'b0;
            wr_state     <= W_IDLE;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  assign ar_idx      = s_axi.araddr[AW-1:2];
  assign ar_in_range = {1'b0, ar_idx} < NUM_REGS_W;

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (ar_idx == IW'(k)) rd_word = regs[k];
    end
  end

  // regs are sampled before this edge's write lands, so a same-edge
  // read/write collision returns the old value.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rd_state     <= R_IDLE;
      s_axi.rvalid <= 1'b0;
      s_axi.rdata  <= '0;
      s_axi.rresp  <= RESP_OKAY;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (ar_hs) begin
            s_axi.rvalid <= 1'b1;
            s_axi.rdata  <= ar_in_range ? rd_word : '0;
            s_axi.rresp  <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
            rd_state     <= R_DATA;
          end
        end
        R_DATA: begin
          if (s_axi.rready) begin
            s_axi.rvalid <= 1'b0;
            rd_state     <= R_IDLE;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg_out
    assign reg_out[32*k +: 32] = regs[k];
  end

  // Protection bits and byte offset within a word carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0]};

endmodule
